mips_cpu_muldiv: RTL and testbench

MIPS_CPU_MULDIV -- requirements
Module: mips_cpu_muldiv

---
 rtl/mips_cpu_definitions.sv | 57 +++++
 rtl/mips_cpu_muldiv_core.sv | 75 +++++++
 rtl/mips_cpu_muldiv.sv | 119 +++++++++++
 tb/tb_mips_cpu_muldiv.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/mips_cpu_definitions.sv
// Shared MIPS CPU types: instruction fields, CPU control state and the
// multiply/divide unit's operation and FSM encodings.
package mips_cpu_definitions;

    typedef enum logic [5:0] {
        OPC_SPECIAL = 6'h00,
        OPC_J       = 6'h02,
        OPC_JAL     = 6'h03,
        OPC_BEQ     = 6'h04,
        OPC_BNE     = 6'h05,
        OPC_ADDIU   = 6'h09,
        OPC_LW      = 6'h23,
        OPC_SW      = 6'h2b
    } opcode_t;

    typedef enum logic [5:0] {
        FN_SLL   = 6'h00,
        FN_JR    = 6'h08,
        FN_MFHI  = 6'h10,
        FN_MTHI  = 6'h11,
        FN_MFLO  = 6'h12,
        FN_MTLO  = 6'h13,
        FN_MULT  = 6'h18,
        FN_MULTU = 6'h19,
        FN_DIV   = 6'h1a,
        FN_DIVU  = 6'h1b,
        FN_ADDU  = 6'h21,
        FN_SUBU  = 6'h23
    } function_t;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WRITEBACK,
        ST_HALTED
    } state_t;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6
    } muldiv_op_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MUL   = 2'd1,
        S_DIV   = 2'd2,
        S_FIXUP = 2'd3
    } muldiv_state_t;

endpackage

// File: rtl/mips_cpu_muldiv_core.sv
// Unsigned iteration datapath: one radix-2 shift-add or restoring-divide step
// per clock on magnitudes, plus the iteration counter.
module mips_cpu_muldiv_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             div_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             last_o
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] m_q;
    logic [CW-1:0]    cnt_q;
    logic             div_q;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    // Multiply: {acc,q} shifts right, q[0] gates the add. Divide: {acc,q}
    // shifts left and diff[WIDTH] is the borrow of the trial subtraction.
    always_comb begin
        acc_d   = acc_q;
        q_d     = q_q;
        sum     = {1'b0, acc_q} + ({(WIDTH+1){q_q[0]}} & {1'b0, m_q});
        shifted = {acc_q, q_q[WIDTH-1]};
        diff    = shifted - {1'b0, m_q};
        if (div_q) begin
            if (!diff[WIDTH]) begin
                acc_d = diff[WIDTH-1:0];
                q_d   = {q_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = shifted[WIDTH-1:0];
                q_d   = {q_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_d = sum[WIDTH:1];
            q_d   = {sum[0], q_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
            q_q   <= '0;
            m_q   <= '0;
            cnt_q <= '0;
            div_q <= 1'b0;
        end else if (load_i) begin
            acc_q <= '0;
            q_q   <= a_i;
            m_q   <= b_i;
            cnt_q <= '0;
            div_q <= div_i;
        end else if (step_i) begin
            acc_q <= acc_d;
            q_q   <= q_d;
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign hi_o   = acc_q;
    assign lo_o   = q_q;
    assign last_o = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/mips_cpu_muldiv.sv
// MIPS HI/LO multiply-divide unit: fixed-latency sign-magnitude MULT/DIV
// around an unsigned iterative core, plus direct MTHI/MTLO writes.
module mips_cpu_muldiv
    import mips_cpu_definitions::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  muldiv_op_t       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output muldiv_state_t    dbg_state_o
);

    muldiv_state_t    state_q;
    logic             busy_q, done_q, dbz_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             neg_q, neg_rem_q, div_q, dz_q;

    logic             op_signed, op_div, op_iter, start_iter;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] core_hi, core_lo;
    logic             core_last;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    assign op_signed  = (op == OP_MULT) || (op == OP_DIV);
    assign op_div     = (op == OP_DIV) || (op == OP_DIVU);
    assign op_iter    = op_div || (op == OP_MULT) || (op == OP_MULTU);
    assign start_iter = start && (state_q == S_IDLE) && op_iter;
    assign a_mag      = (op_signed && a[WIDTH-1]) ? -a : a;
    assign b_mag      = (op_signed && b[WIDTH-1]) ? -b : b;

    mips_cpu_muldiv_core #(.WIDTH(WIDTH)) u_core (
        .clk    (clk),
        .reset  (reset),
        .load_i (start_iter),
        .div_i  (op_div),
        .step_i ((state_q == S_MUL) || (state_q == S_DIV)),
        .a_i    (a_mag),
        .b_i    (b_mag),
        .hi_o   (core_hi),
        .lo_o   (core_lo),
        .last_o (core_last)
    );

    // Divide by zero: the core leaves |a| as remainder, so the dividend-sign
    // correction restores the original a; only the quotient is forced.
    assign prod     = {core_hi, core_lo};
    assign prod_fix = neg_q ? -prod : prod;
    assign quo_fix  = dz_q ? '1 : (neg_q ? -core_lo : core_lo);
    assign rem_fix  = neg_rem_q ? -core_hi : core_hi;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            div_q     <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_iter) begin
                        state_q   <= op_div ? S_DIV : S_MUL;
                        busy_q    <= 1'b1;
                        neg_q     <= op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_rem_q <= op_signed && a[WIDTH-1];
                        div_q     <= op_div;
                        dz_q      <= op_div && (b == '0);
                    end else if (start && op == OP_MTHI) begin
                        hi_q <= a;
                    end else if (start && op == OP_MTLO) begin
                        lo_q <= a;
                    end
                end
                S_MUL, S_DIV: begin
                    if (core_last) state_q <= S_FIXUP;
                end
                S_FIXUP: begin
                    if (div_q) begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end else begin
                        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fix[WIDTH-1:0];
                    end
                    done_q  <= 1'b1;
                    dbz_q   <= dz_q;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Directed bench for mips_cpu_muldiv at WIDTH=32 with hand-computed results.
module tb_mips_cpu_muldiv;
    import mips_cpu_definitions::*;

    logic          clk;
    logic          reset;
    logic          start;
    muldiv_op_t    op;
    logic [31:0]   a, b;
    logic          busy, done, div_by_zero;
    logic [31:0]   hi, lo;
    muldiv_state_t dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    mips_cpu_muldiv #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo),
        .dbg_state_o (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Launch one iterative op at the next negedge, then follow it to done.
    task automatic run_op(input string tag, input muldiv_op_t o,
                          input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input logic exp_dz, input bit b2b, input bit inject);
        logic [31:0] hold_hi, hold_lo;
        int lat;
        bit busy_ok, hold_ok;
        @(negedge clk);
        if (b2b) check({tag, "_b2b_done"}, done, 1'b1);
        hold_hi = hi;
        hold_lo = lo;
        op = o; a = av; b = bv; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        op = muldiv_op_t'($urandom_range(0, 6));
        lat = 0;
        busy_ok = 1'b1;
        hold_ok = 1'b1;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (inject && lat == 5) begin
                op = OP_MTHI; a = 32'h1234; start = 1'b1;
            end else if (inject && lat == 6) begin
                start = 1'b0;
            end
            if (done) break;
            if (!busy) busy_ok = 1'b0;
            if (hi !== hold_hi || lo !== hold_lo) hold_ok = 1'b0;
        end
        start = 1'b0;
        check({tag, "_latency"}, lat, 33);
        check({tag, "_busy_iter"}, busy_ok, 1'b1);
        check({tag, "_hold"}, hold_ok, 1'b1);
        check({tag, "_busy_done"}, busy, 1'b0);
        check({tag, "_hi"}, hi, exp_hi);
        check({tag, "_lo"}, lo, exp_lo);
        check({tag, "_dbz"}, div_by_zero, exp_dz);
    endtask

    task automatic direct_op(input string tag, input muldiv_op_t o, input logic [31:0] av,
                             input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        @(negedge clk);
        op = o; a = av; b = 32'h0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, "_hi"}, hi, exp_hi);
        check({tag, "_lo"}, lo, exp_lo);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        @(posedge clk);
        #1;
        check({tag, "_done_next"}, done, 1'b0);
        check({tag, "_busy_next"}, busy, 1'b0);
    endtask

    initial begin
        bit seen;
        reset = 1'b1; start = 1'b0; op = OP_NOP; a = '0; b = '0;
        #2 reset = 1'b0;
        #1;
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_state", dbg_state, S_IDLE);
        @(negedge clk);
        reset = 1'b1;

        run_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0, 1'b0);
        run_op("mult_neg", OP_MULT, 32'hFFFFFFFD, 32'h7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b1, 1'b0);
        run_op("mult_min", OP_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 1'b0, 1'b1, 1'b0);
        run_op("div_neg", OP_DIV, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b1, 1'b0);
        run_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 1'b1, 1'b0);
        run_op("divu_dz", OP_DIVU, 32'h5, 32'h0, 32'h5, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0);
        run_op("div_dz", OP_DIV, 32'hFFFFFFF8, 32'h0, 32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0);
        run_op("divu_big", OP_DIVU, 32'hFFFFFFFF, 32'h10, 32'hF, 32'h0FFFFFFF, 1'b0, 1'b1, 1'b0);
        run_op("div_negb", OP_DIV, 32'h7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD, 1'b0, 1'b1, 1'b0);
        run_op("multu_inj", OP_MULTU, 32'h00010000, 32'h00010000, 32'h1, 32'h0, 1'b0, 1'b0, 1'b1);

        direct_op("mtlo", OP_MTLO, 32'hABCD, 32'h1, 32'hABCD);
        direct_op("mthi", OP_MTHI, 32'h5555, 32'h5555, 32'hABCD);
        direct_op("nop", OP_NOP, 32'hDEAD, 32'h5555, 32'hABCD);
        direct_op("undef", muldiv_op_t'(3'd7), 32'hBEEF, 32'h5555, 32'hABCD);

        // Reset in the tenth iteration cycle of a divide.
        @(negedge clk);
        op = OP_DIVU; a = 32'd1000; b = 32'd3; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("midrst_hi", hi, 32'h0);
        check("midrst_lo", lo, 32'h0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_state", dbg_state, S_IDLE);
        seen = 1'b0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        check("midrst_no_done", seen, 1'b0);
        reset = 1'b1;
        run_op("divu_after_rst", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
